// File: rtl/nn_seq_if.sv
// Sequencer <-> controller / MAC-bank signal bundle.
// NN_SEQ_PERF_CNT_EN adds the perf_cycles busy-cycle counter output.
interface nn_seq_if #(
  parameter int unsigned PAR     = 10,
  parameter int unsigned IADDR_W = 6,
  parameter int unsigned WADDR_W = 9
);
  logic               start_neuron;
  logic [1:0]         state;
  logic               busy;
  logic [1:0]         layer;
  logic               acc_clr;
  logic               mac_en;
  logic               bias_phase;
  logic [IADDR_W-1:0] in_addr;
  logic [WADDR_W-1:0] w_addr;
  logic               wb_en;
  logic [4:0]         neuron_base;
  logic [PAR-1:0]     lane_valid;
  logic               calculation_done;
`ifdef NN_SEQ_PERF_CNT_EN
  logic [31:0]        perf_cycles;

  modport master (
    output start_neuron, state,
    input  busy, layer, acc_clr, mac_en, bias_phase, in_addr, w_addr,
           wb_en, neuron_base, lane_valid, calculation_done, perf_cycles
  );
  modport slave (
    input  start_neuron, state,
    output busy, layer, acc_clr, mac_en, bias_phase, in_addr, w_addr,
           wb_en, neuron_base, lane_valid, calculation_done, perf_cycles
  );
`else
  modport master (
    output start_neuron, state,
    input  busy, layer, acc_clr, mac_en, bias_phase, in_addr, w_addr,
           wb_en, neuron_base, lane_valid, calculation_done
  );
  modport slave (
    input  start_neuron, state,
    output busy, layer, acc_clr, mac_en, bias_phase, in_addr, w_addr,
           wb_en, neuron_base, lane_valid, calculation_done
  );
`endif
endinterface

// File: rtl/nn_layer_sequencer.sv
// Walks the PAR-wide MAC bank through one layer: clear, accumulate, bias, write-back per group.
// NN_SEQ_PERF_CNT_EN adds a saturating busy-cycle counter on perf_cycles.
module nn_layer_sequencer #(
  parameter int unsigned N_IN    = 62,
  parameter int unsigned N_H1    = 30,
  parameter int unsigned N_H2    = 30,
  parameter int unsigned N_OUT   = 10,
  parameter int unsigned PAR     = 10,
  parameter int unsigned IADDR_W = 6,
  parameter int unsigned WADDR_W = 9
) (
  input logic    clk,
  input logic    rst,
  nn_seq_if.slave bus
);
  localparam int unsigned G0    = (N_H1 + PAR - 1) / PAR;
  localparam int unsigned G1    = (N_H2 + PAR - 1) / PAR;
  localparam int unsigned BASE1 = G0 * (N_IN + 1);
  localparam int unsigned BASE2 = BASE1 + G1 * (N_H1 + 1);
  localparam int unsigned G_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCUM, S_BIAS, S_WRITE, S_DONE
  } st_t;

  function automatic int unsigned fanin_of(input logic [1:0] l);
    case (l)
      2'd0:    return N_IN;
      2'd1:    return N_H1;
      default: return N_H2;
    endcase
  endfunction

  function automatic int unsigned neur_of(input logic [1:0] l);
    case (l)
      2'd0:    return N_H1;
      2'd1:    return N_H2;
      default: return N_OUT;
    endcase
  endfunction

  function automatic int unsigned grps_of(input logic [1:0] l);
    return (neur_of(l) + PAR - 1) / PAR;
  endfunction

  function automatic int unsigned base_of(input logic [1:0] l);
    case (l)
      2'd0:    return 0;
      2'd1:    return BASE1;
      default: return BASE2;
    endcase
  endfunction

  st_t                st_q, st_d;
  logic [1:0]         layer_q, layer_d;
  logic [G_W-1:0]     g_q, g_d;
  logic [IADDR_W-1:0] k_q, k_d;

  logic               busy_q, busy_d;
  logic               acc_clr_q, acc_clr_d;
  logic               mac_en_q, mac_en_d;
  logic               bias_q, bias_d;
  logic [IADDR_W-1:0] in_addr_q, in_addr_d;
  logic [WADDR_W-1:0] w_addr_q, w_addr_d;
  logic               wb_q, wb_d;
  logic [4:0]         nbase_q, nbase_d;
  logic [PAR-1:0]     lane_q, lane_d;
  logic               done_q, done_d;

  int unsigned fanin_q, grps_q, fanin_d, neur_d, row_d;

  // Next-state logic, then outputs decoded from the next state so they leave a flop.
  always_comb begin
    st_d    = st_q;
    layer_d = layer_q;
    g_d     = g_q;
    k_d     = k_q;
    fanin_q = fanin_of(layer_q);
    grps_q  = grps_of(layer_q);

    unique case (st_q)
      S_IDLE: begin
        if (bus.start_neuron && bus.state != 2'b11) begin
          layer_d = bus.state;
          g_d     = '0;
          k_d     = '0;
          st_d    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        k_d  = '0;
        st_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (32'(k_q) == fanin_q - 1) st_d = S_BIAS;
        else                         k_d  = k_q + IADDR_W'(1);
      end
      S_BIAS:  st_d = S_WRITE;
      S_WRITE: begin
        if (32'(g_q) == grps_q - 1) begin
          st_d = S_DONE;
        end else begin
          g_d  = g_q + G_W'(1);
          st_d = S_CLEAR;
        end
      end
      S_DONE:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase

    fanin_d   = fanin_of(layer_d);
    neur_d    = neur_of(layer_d);
    row_d     = base_of(layer_d) + 32'(g_d) * (fanin_d + 1);

    busy_d    = (st_d != S_IDLE);
    acc_clr_d = (st_d == S_CLEAR);
    mac_en_d  = (st_d == S_ACCUM) || (st_d == S_BIAS);
    bias_d    = (st_d == S_BIAS);
    in_addr_d = (st_d == S_ACCUM) ? k_d : '0;
    w_addr_d  = '0;
    if (st_d == S_ACCUM)     w_addr_d = WADDR_W'(row_d + 32'(k_d));
    else if (st_d == S_BIAS) w_addr_d = WADDR_W'(row_d + fanin_d);
    wb_d      = (st_d == S_WRITE);
    nbase_d   = '0;
    lane_d    = '0;
    if (st_d == S_WRITE) begin
      nbase_d = 5'(32'(g_d) * PAR);
      for (int unsigned i = 0; i < PAR; i++) begin
        lane_d[i] = (32'(g_d) * PAR + i) < neur_d;
      end
    end
    done_d    = (st_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= S_IDLE;
      layer_q   <= '0;
      g_q       <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      acc_clr_q <= 1'b0;
      mac_en_q  <= 1'b0;
      bias_q    <= 1'b0;
      in_addr_q <= '0;
      w_addr_q  <= '0;
      wb_q      <= 1'b0;
      nbase_q   <= '0;
      lane_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      st_q      <= st_d;
      layer_q   <= layer_d;
      g_q       <= g_d;
      k_q       <= k_d;
      busy_q    <= busy_d;
      acc_clr_q <= acc_clr_d;
      mac_en_q  <= mac_en_d;
      bias_q    <= bias_d;
      in_addr_q <= in_addr_d;
      w_addr_q  <= w_addr_d;
      wb_q      <= wb_d;
      nbase_q   <= nbase_d;
      lane_q    <= lane_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy             = busy_q;
  assign bus.layer            = layer_q;
  assign bus.acc_clr          = acc_clr_q;
  assign bus.mac_en           = mac_en_q;
  assign bus.bias_phase       = bias_q;
  assign bus.in_addr          = in_addr_q;
  assign bus.w_addr           = w_addr_q;
  assign bus.wb_en            = wb_q;
  assign bus.neuron_base      = nbase_q;
  assign bus.lane_valid       = lane_q;
  assign bus.calculation_done = done_q;

`ifdef NN_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  // Saturating count of busy cycles; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)                          perf_q <= '0;
    else if (busy_q && perf_q != '1)  perf_q <= perf_q + 32'd1;
  end

  assign bus.perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Scoreboard bench for nn_layer_sequencer; with NN_SEQ_PERF_CNT_EN it uses N_H1=25 and checks perf_cycles.
`timescale 1ns/1ps
module tb_nn_layer_sequencer;
  localparam int unsigned PAR = 10;
`ifdef NN_SEQ_PERF_CNT_EN
  localparam int unsigned N_H1 = 25;
  localparam int unsigned FANIN_T[3] = '{62, 25, 30};
  localparam int unsigned NEUR_T[3]  = '{25, 30, 10};
  localparam int unsigned GRP_T[3]   = '{3, 3, 1};
  localparam int unsigned BASE_T[3]  = '{0, 189, 267};
  localparam int unsigned LAT_T[3]   = '{196, 85, 34};
`else
  localparam int unsigned N_H1 = 30;
  localparam int unsigned FANIN_T[3] = '{62, 30, 30};
  localparam int unsigned NEUR_T[3]  = '{30, 30, 10};
  localparam int unsigned GRP_T[3]   = '{3, 3, 1};
  localparam int unsigned BASE_T[3]  = '{0, 189, 282};
  localparam int unsigned LAT_T[3]   = '{196, 100, 34};
`endif

  localparam int EV_FIRST = 0;
  localparam int EV_BIAS  = 1;
  localparam int EV_WB    = 2;
  localparam int EV_DONE  = 3;

  typedef struct {
    int          kind;
    int unsigned a;
    int unsigned b;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  ev_t         sb[$];
  bit          seen_mac = 1'b0;
  int unsigned prev_w = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nn_seq_if #(.PAR(PAR), .IADDR_W(6), .WADDR_W(9)) bus ();

  nn_layer_sequencer #(
    .N_IN(62), .N_H1(N_H1), .N_H2(30), .N_OUT(10),
    .PAR(PAR), .IADDR_W(6), .WADDR_W(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int unsigned a, input int unsigned b,
                           input string name);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected event a=%0d b=%0d at cycle %0d", name, a, b, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.a != a || e.b != b) begin
        bad++;
        $display("FAIL %s: got kind=%0d a=%0d b=%0d expected kind=%0d a=%0d b=%0d (cycle %0d)",
                 name, kind, a, b, e.kind, e.a, e.b, cyc);
      end
    end
  endtask

  task automatic push_ev(input int kind, input int unsigned a, input int unsigned b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    sb.push_back(e);
  endtask

  // Expected event stream for one complete run of layer l.
  task automatic push_run(input int l, input int unsigned done_cyc);
    int unsigned row, lanes;
    push_ev(EV_FIRST, BASE_T[l], 0);
    for (int g = 0; g < int'(GRP_T[l]); g++) begin
      row = BASE_T[l] + 32'(g) * (FANIN_T[l] + 1);
      push_ev(EV_BIAS, row + FANIN_T[l] - 1, row + FANIN_T[l]);
      lanes = 0;
      for (int i = 0; i < int'(PAR); i++)
        if (32'(g) * PAR + 32'(i) < NEUR_T[l]) lanes |= (32'd1 << i);
      push_ev(EV_WB, 32'(g) * PAR, lanes);
    end
    push_ev(EV_DONE, done_cyc, 0);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!bus.calculation_done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!bus.calculation_done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no calculation_done expected one within %0d cycles", limit);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_busy"},   32'(bus.busy), 0);
    chk({name, "_mac_en"}, 32'(bus.mac_en), 0);
    chk({name, "_done"},   32'(bus.calculation_done), 0);
  endtask

  // Issue a run at the current negedge and check its CLEAR cycle.
  task automatic single_run(input int l);
    int unsigned c;
    c = cyc;
    bus.state        = 2'(l);
    bus.start_neuron = 1'b1;
    push_run(l, c + LAT_T[l]);
    @(negedge clk);
    bus.start_neuron = 1'b0;
    chk("clear_busy",  32'(bus.busy), 1);
    chk("clear_acc",   32'(bus.acc_clr), 1);
    chk("clear_layer", 32'(bus.layer), 32'(l));
    wait_done(400);
    @(negedge clk);
    chk("post_done_busy", 32'(bus.busy), 0);
  endtask

  // Monitor: every observable output event is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      seen_mac = 1'b0;
    end else begin
      if (!bus.busy) seen_mac = 1'b0;
      if (bus.mac_en && !bus.bias_phase && !seen_mac) begin
        seen_mac = 1'b1;
        expect_ev(EV_FIRST, 32'(bus.w_addr), 0, "first_waddr");
      end
      if (bus.bias_phase) expect_ev(EV_BIAS, prev_w, 32'(bus.w_addr), "bias_waddr");
      if (bus.wb_en)
        expect_ev(EV_WB, 32'(bus.neuron_base), 32'(bus.lane_valid), "writeback");
      if (bus.calculation_done) expect_ev(EV_DONE, cyc, 0, "done_cycle");
      if (bus.mac_en && !bus.bias_phase) prev_w = 32'(bus.w_addr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c, e0, e1, e2;
    rst              = 1'b1;
    bus.start_neuron = 1'b0;
    bus.state        = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(bus.busy), 0);
    chk("rst_waddr",  32'(bus.w_addr), 0);
    chk("rst_lanes",  32'(bus.lane_valid), 0);
    chk("rst_acc",    32'(bus.acc_clr), 0);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk_quiet("idle");
    end

    // Single layer-0 run.
    single_run(0);
`ifdef NN_SEQ_PERF_CNT_EN
    chk("perf_run0", bus.perf_cycles, 196);
`endif

    // Controller chain 00 -> 01 -> 10 with start held.
    c                = cyc;
    bus.state        = 2'b00;
    bus.start_neuron = 1'b1;
    e0 = c + LAT_T[0];
    e1 = e0 + 1 + LAT_T[1];
    e2 = e1 + 1 + LAT_T[2];
    push_run(0, e0);
    wait_done(400);
    bus.state = 2'b01;
    push_run(1, e1);
    repeat (2) @(negedge clk);
    chk("chain_layer1", 32'(bus.layer), 1);
    wait_done(400);
    bus.state = 2'b10;
    push_run(2, e2);
    repeat (2) @(negedge clk);
    chk("chain_layer2", 32'(bus.layer), 2);
    wait_done(400);
    bus.start_neuron = 1'b0;
    bus.state        = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk("chain_end_busy", 32'(bus.busy), 0);
    end

    // Illegal layer select must never start a run.
    bus.state        = 2'b11;
    bus.start_neuron = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk_quiet("illegal");
    end
    bus.start_neuron = 1'b0;
    bus.state        = 2'b00;
    @(negedge clk);

    // Reset in cycle 50 of a layer-0 run, then a full restart.
    c                = cyc;
    bus.start_neuron = 1'b1;
    push_ev(EV_FIRST, 0, 0);
    @(negedge clk);
    bus.start_neuron = 1'b0;
    while (cyc < c + 50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_quiet("abort");
    chk("abort_waddr", 32'(bus.w_addr), 0);
    chk("abort_inaddr", 32'(bus.in_addr), 0);
    chk("abort_layer", 32'(bus.layer), 0);
    repeat (5) begin
      @(negedge clk);
      chk_quiet("abort_idle");
    end
    single_run(0);
`ifdef NN_SEQ_PERF_CNT_EN
    chk("perf_restart", bus.perf_cycles, 196);
`endif

    repeat (5) @(negedge clk);
    while (sb.size() != 0) begin
      ev_t e;
      e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event: got nothing expected kind=%0d a=%0d b=%0d", e.kind, e.a, e.b);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
